// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int WORD              = 32;
  localparam int INSTR_WORDS       = 3;
  localparam int IFU_DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: reads three consecutive program words for a PC
// and returns them together, with flush/drain handling and a range check.
module instr_fetch_unit #(
  parameter int WORD            = 32,
  parameter int MEM_DEPTH       = 1024,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic [WORD-1:0] fetch_addr,
  input  logic            flush,
  output logic            fetch_busy,
  output logic            fetch_done,
  output logic            fetch_err,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] imm,
  output logic [WORD-1:0] imm2,
  output logic            mem_re,
  output logic [WORD-1:0] mem_addr,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_rvalid
);

  import instr_fetch_unit_pkg::*;

  localparam int              CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WORD-1:0] LAST_BASE = WORD'(MEM_DEPTH - INSTR_WORDS);
  localparam logic [1:0]      ISSUE_END = 2'(INSTR_WORDS);
  localparam logic [1:0]      CAP_LAST  = 2'(INSTR_WORDS - 1);

  ifu_state_t       state, state_n;
  logic [WORD-1:0]  base, base_n;
  logic [1:0]       issue_idx, issue_n;
  logic [1:0]       cap_idx, cap_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [WORD-1:0]  cap0, cap0_n, cap1, cap1_n;
  logic [WORD-1:0]  instr_n, imm_n, imm2_n, mem_addr_n;
  logic             mem_re_n, done_n, err_n;
  logic             aborting, rd_retire;

  assign fetch_busy = (state != IDLE);

  // Next-state logic; the first two words are staged in cap0/cap1 so the
  // visible outputs only change when the whole fetch commits.
  always_comb begin
    state_n    = state;
    base_n     = base;
    issue_n    = issue_idx;
    cap_n      = cap_idx;
    cap0_n     = cap0;
    cap1_n     = cap1;
    instr_n    = instr;
    imm_n      = imm;
    imm2_n     = imm2;
    mem_re_n   = 1'b0;
    mem_addr_n = mem_addr;
    done_n     = 1'b0;
    err_n      = 1'b0;
    aborting   = 1'b0;
    rd_retire  = mem_rvalid && (state != IDLE) && (outstanding != '0);

    case (state)
      IDLE: begin
        if (fetch_req && !flush) begin
          if (fetch_addr <= LAST_BASE) begin
            base_n     = fetch_addr;
            mem_re_n   = 1'b1;
            mem_addr_n = fetch_addr;
            issue_n    = 2'd1;
            cap_n      = 2'd0;
            state_n    = ISSUE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ISSUE, WAIT: begin
        if (flush) begin
          aborting = 1'b1;
        end else begin
          if (state == ISSUE) begin
            if (issue_idx == ISSUE_END) begin
              state_n = WAIT;
            end else begin
              mem_re_n   = 1'b1;
              mem_addr_n = base + WORD'(issue_idx);
              issue_n    = issue_idx + 2'd1;
            end
          end
          if (mem_rvalid) begin
            cap_n = cap_idx + 2'd1;
            if (cap_idx == CAP_LAST) begin
              instr_n = cap0;
              imm_n   = cap1;
              imm2_n  = mem_rdata;
              done_n  = 1'b1;
              state_n = IDLE;
            end else if (cap_idx == 2'd0) begin
              cap0_n = mem_rdata;
            end else begin
              cap1_n = mem_rdata;
            end
          end
        end
      end
      default: ;
    endcase

    outstanding_n = outstanding + CNT_W'(mem_re_n) - CNT_W'(rd_retire);

    // An aborted fetch leaves only once every issued read has come back.
    if (aborting || state == DRAIN) begin
      state_n = (outstanding_n == '0) ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      issue_idx   <= '0;
      cap_idx     <= '0;
      outstanding <= '0;
      cap0        <= '0;
      cap1        <= '0;
      instr       <= '0;
      imm         <= '0;
      imm2        <= '0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      fetch_done  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_n;
      base        <= base_n;
      issue_idx   <= issue_n;
      cap_idx     <= cap_n;
      outstanding <= outstanding_n;
      cap0        <= cap0_n;
      cap1        <= cap1_n;
      instr       <= instr_n;
      imm         <= imm_n;
      imm2        <= imm2_n;
      mem_re      <= mem_re_n;
      mem_addr    <= mem_addr_n;
      fetch_done  <= done_n;
      fetch_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: latency-programmable memory model,
// vector table, hand-written corner sequences and randomized fetches.
module tb_instr_fetch_unit;

  localparam int W     = 32;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_req, flush;
  logic [W-1:0] fetch_addr;
  logic         fetch_busy, fetch_done, fetch_err;
  logic [W-1:0] instr, imm, imm2;
  logic         mem_re, mem_rvalid;
  logic [W-1:0] mem_addr, mem_rdata;

  instr_fetch_unit #(.WORD(W), .MEM_DEPTH(DEPTH), .MAX_OUTSTANDING(3)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .flush(flush), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .fetch_err(fetch_err), .instr(instr), .imm(imm), .imm2(imm2),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:DEPTH-1];
  int           lat = 1;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_instr, exp_imm, exp_imm2;

  // Program memory: a read sampled at an edge returns its data lat cycles later.
  initial begin : memory_model
    logic         pv [0:7];
    logic [W-1:0] pd [0:7];
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    mem_rvalid <= 1'b0;
    mem_rdata  <= '0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 7; i++) begin
        pv[i] = pv[i+1];
        pd[i] = pd[i+1];
      end
      pv[7] = 1'b0;
      if (mem_re === 1'b1) begin
        pv[lat-1] = 1'b1;
        pd[lat-1] = mem[mem_addr[9:0]];
      end
      mem_rvalid <= pv[0];
      mem_rdata  <= pd[0];
    end
  end

  task automatic applyStimulus(input logic req, input logic [W-1:0] addr, input logic fl);
    fetch_req  = req;
    fetch_addr = addr;
    flush      = fl;
  endtask

  task automatic checkOutput(input string name, input int t, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 0, W'(fetch_busy), '0);
    checkOutput({tag, "_done"}, 0, W'(fetch_done), '0);
    checkOutput({tag, "_err"}, 0, W'(fetch_err), '0);
    checkOutput({tag, "_re"}, 0, W'(mem_re), '0);
    checkOutput({tag, "_addr"}, 0, mem_addr, '0);
    checkOutput({tag, "_instr"}, 0, instr, '0);
    checkOutput({tag, "_imm"}, 0, imm, '0);
    checkOutput({tag, "_imm2"}, 0, imm2, '0);
  endtask

  // Reference model: request accepted at edge n (t = cycles after edge n).
  // Reads are driven after edges n..n+r-1, read i returns at edge n+i+L,
  // and the unit is idle after the last returned read or the flush edge.
  task automatic runFetch(input logic [W-1:0] addr, input int l, input int f, input int s,
                          output int start, output int ndone, output int nerr);
    int budget, r, endt, tlast;
    bit in_rng, done_exp;
    logic [W-1:0] n0, n1, n2;
    budget = 0;
    while (fetch_busy !== 1'b0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("idle_before_req", budget, W'(fetch_busy), '0);
    lat      = l;
    in_rng   = (addr <= W'(DEPTH - 3));
    r        = (f > 0 && f < 3) ? f : 3;
    done_exp = in_rng && (f == 0 || f > 3 + l);
    if (!in_rng)       endt = 0;
    else if (done_exp) endt = 3 + l;
    else               endt = (f > r + l) ? f : r + l;
    n0 = mem[addr[9:0]];
    n1 = mem[addr[9:0] + 10'd1];
    n2 = mem[addr[9:0] + 10'd2];
    tlast = (endt > 1) ? endt : 1;
    start = 0;
    ndone = 0;
    nerr  = 0;
    applyStimulus(1'b1, addr, 1'b0);
    for (int t = 0; t <= tlast; t++) begin
      @(negedge clk);
      if (t == 0) start = cyc;
      if (fetch_done === 1'b1) ndone++;
      if (fetch_err === 1'b1) nerr++;
      if (done_exp && t == 3 + l) begin
        exp_instr = n0;
        exp_imm   = n1;
        exp_imm2  = n2;
      end
      checkOutput("busy", t, W'(fetch_busy), W'(in_rng && t < endt));
      checkOutput("mem_re", t, W'(mem_re), W'(in_rng && t < r));
      if (in_rng && t < r) checkOutput("mem_addr", t, mem_addr, addr + W'(t));
      checkOutput("done", t, W'(fetch_done), W'(done_exp && t == 3 + l));
      checkOutput("err", t, W'(fetch_err), W'(!in_rng && t == 0));
      checkOutput("instr", t, instr, exp_instr);
      checkOutput("imm", t, imm, exp_imm);
      checkOutput("imm2", t, imm2, exp_imm2);
      applyStimulus(s > 0 && t == s, addr + 32'd30, f > 0 && t == f - 1);
    end
  endtask

  typedef struct {
    logic [W-1:0] addr;
    int           lat;
    int           flush_at;
    int           spur_at;
    int           exp_done;
    int           exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int st, st2, nd, ne, l, f, s, smax;
    logic [W-1:0] a;

    vecs[0] = '{32'd6,          1, 0, 0, 1, 0};
    vecs[1] = '{32'd1022,       1, 0, 0, 0, 1};
    vecs[2] = '{32'd0,          2, 1, 0, 0, 0};
    vecs[3] = '{32'd3,          2, 0, 0, 1, 0};
    vecs[4] = '{32'd12,         1, 0, 2, 1, 0};
    vecs[5] = '{32'd1021,       1, 0, 0, 1, 0};
    vecs[6] = '{32'd1023,       2, 0, 0, 0, 1};
    vecs[7] = '{32'hFFFF_FFFF,  1, 0, 0, 0, 1};
    vecs[8] = '{32'd15,         2, 5, 0, 0, 0};
    vecs[9] = '{32'd18,         3, 4, 1, 0, 0};

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[6] = 32'h0A00_0001;
    mem[7] = 32'h0000_8003;
    mem[8] = 32'h0000_0005;
    exp_instr = '0;
    exp_imm   = '0;
    exp_imm2  = '0;

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      runFetch(vecs[i].addr, vecs[i].lat, vecs[i].flush_at, vecs[i].spur_at, st, nd, ne);
      checkOutput("tbl_done_count", i, W'(nd), W'(vecs[i].exp_done));
      checkOutput("tbl_err_count", i, W'(ne), W'(vecs[i].exp_err));
    end

    // Request and flush together in IDLE: dropped, no error even if out of range.
    applyStimulus(1'b1, 32'd6, 1'b1);
    @(negedge clk);
    checkOutput("req_flush_busy", 0, W'(fetch_busy), '0);
    checkOutput("req_flush_re", 0, W'(mem_re), '0);
    applyStimulus(1'b1, 32'd2000, 1'b1);
    @(negedge clk);
    checkOutput("req_flush_err", 0, W'(fetch_err), '0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);

    // Back-to-back fetches start five cycles apart with L=1.
    runFetch(32'd0, 1, 0, 0, st, nd, ne);
    runFetch(32'd3, 1, 0, 0, st2, nd, ne);
    checkOutput("b2b_spacing", 0, W'(st2 - st), W'(5));
    checkOutput("b2b_done_count", 0, W'(nd), W'(1));

    // Reset in WAIT with two reads still outstanding (L=3).
    lat = 3;
    applyStimulus(1'b1, 32'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_busy", 4, W'(fetch_busy), W'(1));
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("mid_reset");
    rst = 1'b0;
    exp_instr = '0;
    exp_imm   = '0;
    exp_imm2  = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      checkOutput("post_reset_busy", t, W'(fetch_busy), '0);
      checkOutput("post_reset_done", t, W'(fetch_done), '0);
      checkOutput("post_reset_instr", t, instr, '0);
    end
    runFetch(32'd9, 1, 0, 0, st, nd, ne);
    checkOutput("post_reset_done_count", 0, W'(nd), W'(1));

    // Randomized fetches with optional flush and ignored mid-fetch requests.
    for (int k = 0; k < 40; k++) begin
      l = int'($urandom_range(1, 3));
      if ($urandom_range(0, 9) < 2) a = 32'd1022 + $urandom_range(0, 2000);
      else                          a = 32'd3 * $urandom_range(0, 340);
      f = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3 + l)) : 0;
      smax = (f > 0) ? f - 1 : 2 + l;
      if (smax < 1) smax = 1;
      s = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, smax)) : 0;
      runFetch(a, l, f, s, st, nd, ne);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
